// File: rtl/register_uart_reporter_pkg.sv
// Shared parameters, FSM encodings and ASCII helpers for the register UART reporter.
// Contents:
//   REG_WIDTH_DEFAULT - default width of the monitored CPU register
//   ASCII_CR/ASCII_LF - line terminator characters sent after every report
//   state_e           - report sequencer states
//   tx_state_e        - UART transmitter states
//   nibble_to_ascii   - 4-bit value to uppercase ASCII hex digit
package register_uart_reporter_pkg;

  localparam int unsigned REG_WIDTH_DEFAULT = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // '0'-'9' map to 0x30-0x39, 'A'-'F' map to 0x41-0x46
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/register_uart_reporter_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte interface.
// A byte offered during the last clock of a stop bit is accepted on that edge,
// so back-to-back characters go out with no idle gap.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset
//   data_i  - byte to send
//   valid_i - data_i is valid
//   ready_o - transmitter accepts data_i on this edge when valid_i is high
//   txd_o   - serial line, idle high
module uart_tx
  import register_uart_reporter_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o
);

  localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             bit_end_c;

  assign bit_end_c = (cnt_q == CNT_LAST);

  // Framing sequencer; shift_q[0] is always the data bit currently on the line
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (valid_i) begin
          shift_d = data_i;
          cnt_d   = '0;
          txd_d   = 1'b0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (valid_i) begin
            shift_d = data_i;
            txd_d   = 1'b0;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
    // Ready is registered: predicted from the state the line will be in next cycle
    ready_d = (state_d == TX_IDLE) || ((state_d == TX_STOP) && (cnt_d == CNT_LAST));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
    end
  end

  assign txd_o   = txd_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/register_uart_reporter.sv
// Watches a CPU register and prints every new value on a UART as uppercase hex
// followed by CR LF. Changes arriving during a report are collapsed: only the
// value present when the sequencer is idle again is reported.
// Ports:
//   clock          - clock, rising edge
//   isReset        - synchronous active-low reset
//   register1Value - live register value
//   txd            - UART line, 8N1, idle high
//   busy           - high while a report frame is on the line
//   overrun        - sticky: more than one change seen during one report
module register_uart_reporter
  import register_uart_reporter_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = REG_WIDTH_DEFAULT,
  parameter int unsigned CLOCKS_PER_BIT = 434
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  output logic                      txd,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned NDIG   = (REGISTER_WIDTH + 3) / 4;
  localparam int unsigned PAD_W  = 4 * NDIG;
  localparam int unsigned NCHAR  = NDIG + 2;
  localparam int unsigned CHAR_W = $clog2(NCHAR);
  localparam int unsigned CNT_W  = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_EARLY = CNT_W'(CLOCKS_PER_BIT - 2);
  localparam logic [CHAR_W-1:0] CHAR_CR   = CHAR_W'(NDIG);
  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(NCHAR - 1);

  state_e                    state_q, state_d;
  logic [REGISTER_WIDTH-1:0] sample_q;
  logic [REGISTER_WIDTH-1:0] last_q, last_d;
  logic [PAD_W-1:0]          snap_q, snap_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [CHAR_W-1:0]         char_cnt_q, char_cnt_d;
  logic                      pending_q, pending_d;
  logic                      overrun_q, overrun_d;
  logic                      busy_q, busy_d;

  logic                      tx_valid_c;
  logic                      tx_ready;
  logic [7:0]                tx_byte_c;
  logic [3:0]                nib_c;
  logic                      clk_last_c;

  assign clk_last_c = (clk_cnt_q == CNT_LAST);

  // Character for the current position: hex digits MS nibble first, then CR, LF
  always_comb begin
    nib_c     = '0;
    tx_byte_c = ASCII_LF;
    if (char_cnt_q < CHAR_CR) begin
      nib_c     = 4'(snap_q >> (4 * (NDIG - 1 - int'(char_cnt_q))));
      tx_byte_c = nibble_to_ascii(nib_c);
    end else if (char_cnt_q == CHAR_CR) begin
      tx_byte_c = ASCII_CR;
    end
  end

  // Report sequencer; bit timing mirrors uart_tx and re-syncs on each LOAD handshake
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    snap_d     = snap_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    char_cnt_d = char_cnt_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    tx_valid_c = 1'b0;

    // A change during a report only counts if it moves away from the value being sent
    if ((state_q != IDLE) && (register1Value != sample_q) && (register1Value != last_q)) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (sample_q != last_q) begin
          snap_d     = PAD_W'(sample_q);
          last_d     = sample_q;
          char_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        tx_valid_c = 1'b1;
        if (tx_ready) begin
          clk_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (clk_last_c) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_last_c) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        // More characters: hand over during the last stop-bit clock to avoid a gap
        if (char_cnt_q == CHAR_LAST) begin
          if (clk_last_c) begin
            clk_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end else if (clk_cnt_q == CNT_EARLY) begin
          clk_cnt_d  = '0;
          char_cnt_d = char_cnt_q + 1'b1;
          state_d    = LOAD;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy tracks the frame on the line: the first LOAD cycle precedes the start bit
    busy_d = (state_d != IDLE) && !((state_d == LOAD) && (state_q == IDLE));
  end

  always_ff @(posedge clock) begin
    if (!isReset) begin
      state_q    <= IDLE;
      sample_q   <= '0;
      last_q     <= '0;
      snap_q     <= '0;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      char_cnt_q <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_q   <= register1Value;
      last_q     <= last_d;
      snap_q     <= snap_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      char_cnt_q <= char_cnt_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  uart_tx #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_uart_tx (
    .clk_i  (clock),
    .rst_ni (isReset),
    .data_i (tx_byte_c),
    .valid_i(tx_valid_c),
    .ready_o(tx_ready),
    .txd_o  (txd)
  );

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_register_uart_reporter.sv
// Bench for register_uart_reporter: a line-level reference model for an 8-bit,
// 4-clocks-per-bit instance checked every cycle, directed scenarios decoded
// with a UART receiver, randomized value changes, and a 10-bit instance.
module tb_register_uart_reporter;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       isReset = 1'b0;
  logic [7:0] val_a = 8'h00;
  logic [9:0] val_b = 10'h000;
  logic       txd_a, busy_a, ovr_a;
  logic       txd_b, busy_b, ovr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  register_uart_reporter #(.REGISTER_WIDTH(8), .CLOCKS_PER_BIT(CPB)) dut_a (
    .clock(clock), .isReset(isReset), .register1Value(val_a),
    .txd(txd_a), .busy(busy_a), .overrun(ovr_a)
  );

  register_uart_reporter #(.REGISTER_WIDTH(10), .CLOCKS_PER_BIT(CPB)) dut_b (
    .clock(clock), .isReset(isReset), .register1Value(val_b),
    .txd(txd_b), .busy(busy_b), .overrun(ovr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model of instance A (line levels in a queue) ----------------
  bit         lvl_q[$];
  logic [7:0] m_sample = 8'h00;
  logic [7:0] m_last   = 8'h00;
  bit         m_pending = 0, m_overrun = 0, m_loading = 0, m_tail = 0, m_idle = 1;
  bit         m_armed = 0;
  logic       exp_txd = 1'b1, exp_busy = 1'b0, exp_ovr = 1'b0;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    for (int c = 0; c < CPB; c++) lvl_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB; c++) lvl_q.push_back(b[i]);
    for (int c = 0; c < CPB; c++) lvl_q.push_back(1'b1);
  endfunction

  function automatic void build_report(input logic [7:0] v);
    push_byte(hex_char(v[7:4]));
    push_byte(hex_char(v[3:0]));
    push_byte(8'h0D);
    push_byte(8'h0A);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  initial begin
    forever begin
      @(posedge clock);
      if (!isReset) begin
        lvl_q.delete();
        m_sample = 8'h00; m_last = 8'h00;
        m_pending = 0; m_overrun = 0; m_loading = 0; m_tail = 0;
        exp_txd = 1'b1; exp_busy = 1'b0; exp_ovr = 1'b0;
        m_armed = 1;
      end else begin
        m_idle = (lvl_q.size() == 0) && !m_loading && !m_tail;
        if (!m_idle && val_a != m_sample && val_a != m_last) begin
          if (m_pending) m_overrun = 1;
          m_pending = 1;
        end
        if (m_idle) begin
          m_pending = 0;
          exp_txd = 1'b1; exp_busy = 1'b0;
          if (m_sample != m_last) begin
            m_last = m_sample;
            build_report(m_sample);
            m_loading = 1;
          end
        end else if (m_loading) begin
          m_loading = 0;
          exp_txd = lvl_q.pop_front(); exp_busy = 1'b1;
        end else if (lvl_q.size() > 0) begin
          exp_txd = lvl_q.pop_front(); exp_busy = 1'b1;
          if (lvl_q.size() == 0) m_tail = 1;
        end else begin
          m_tail = 0;
          exp_txd = 1'b1; exp_busy = 1'b0;
        end
        m_sample = val_a;
        exp_ovr = m_overrun;
      end
    end
  end

  // Per-cycle compare of instance A against the model
  initial begin
    forever begin
      @(negedge clock);
      if (m_armed) begin
        check("model_txd", 32'(txd_a), 32'(exp_txd));
        check("model_busy", 32'(busy_a), 32'(exp_busy));
        check("model_overrun", 32'(ovr_a), 32'(exp_ovr));
      end
    end
  end

  // Free-running count of cycles with busy high on instance A
  int busy_cnt = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (busy_a === 1'b1) busy_cnt++;
    end
  end

  // ---------------- directed helpers ----------------
  logic [7:0] rx_buf [0:7];

  function automatic logic line(input int sel);
    return (sel != 0) ? txd_b : txd_a;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_start(input int sel, input int max, output int lat, output bit seen);
    lat = 0;
    seen = 0;
    while (!seen && lat < max) begin
      tick();
      lat++;
      if (line(sel) === 1'b0) seen = 1;
    end
  endtask

  // Entered on cycle 0 of a start bit; samples each bit in its middle
  task automatic rx_bytes(input int sel, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) check("no_gap_start", 32'(line(sel)), 32'd0);
      repeat (2) tick();
      check("start_mid", 32'(line(sel)), 32'd0);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) tick();
        rx_buf[k][b] = line(sel);
      end
      repeat (CPB) tick();
      check("stop_mid", 32'(line(sel)), 32'd1);
      if (k < n - 1) repeat (2) tick();
    end
  endtask

  task automatic check_rx(input string tag, input int n, input logic [39:0] exp);
    for (int k = 0; k < n; k++) check(tag, 32'(rx_buf[k]), 32'(exp[8*(n-1-k) +: 8]));
  endtask

  task automatic wait_idle(input int sel, input int max);
    int c;
    c = 0;
    while (((sel != 0) ? busy_b : busy_a) !== 1'b0 && c < max) begin
      tick();
      c++;
    end
    check("wait_idle_bounded", 32'((((sel != 0) ? busy_b : busy_a) === 1'b0)), 32'd1);
  endtask

  task automatic count_lows(input int cycles, output int lows);
    lows = 0;
    repeat (cycles) begin
      tick();
      if (txd_a !== 1'b1) lows++;
    end
  endtask

  task automatic pulse_reset(input int cycles);
    isReset = 1'b0;
    repeat (cycles) tick();
    isReset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int  lat, lows, b0, r, hold;
  bit  seen;

  initial begin
    // Reset with value 0: quiet line
    repeat (3) tick();
    check("reset_txd", 32'(txd_a), 32'd1);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_overrun", 32'(ovr_a), 32'd0);
    isReset = 1'b1;
    b0 = busy_cnt;
    count_lows(200, lows);
    check("zero_no_frame", 32'(lows), 32'd0);
    check("zero_no_busy", 32'(busy_cnt - b0), 32'd0);

    // 0x00 -> 0x3A: first edge samples, second snapshots, third drives the start bit
    val_a = 8'h3A;
    b0 = busy_cnt;
    wait_start(0, 20, lat, seen);
    check("3a_start_seen", 32'(seen), 32'd1);
    check("3a_start_latency", 32'(lat), 32'd3);
    rx_bytes(0, 4);
    check_rx("3a_bytes", 4, 40'h0033410D0A);
    wait_idle(0, 20);
    check("3a_busy_cycles", 32'(busy_cnt - b0), 32'd160);

    // Nonzero value held through reset is reported; 0x3A->0x05->0x07 overruns
    pulse_reset(2);
    wait_start(0, 20, lat, seen);
    check("auto_report_latency", 32'(lat), 32'd3);
    repeat (20) tick();
    val_a = 8'h05;
    repeat (30) tick();
    val_a = 8'h07;
    wait_idle(0, 200);
    check("overrun_set", 32'(ovr_a), 32'd1);
    wait_start(0, 20, lat, seen);
    check("followup_seen", 32'(seen), 32'd1);
    rx_bytes(0, 4);
    check_rx("followup_bytes", 4, 40'h0030370D0A);
    wait_idle(0, 20);
    count_lows(200, lows);
    check("single_followup", 32'(lows), 32'd0);
    check("overrun_sticky", 32'(ovr_a), 32'd1);

    // 0x3A->0x11->0x3A during a report: nothing further, no overrun
    val_a = 8'h3A;
    pulse_reset(2);
    wait_start(0, 20, lat, seen);
    repeat (20) tick();
    val_a = 8'h11;
    repeat (20) tick();
    val_a = 8'h3A;
    wait_idle(0, 200);
    count_lows(200, lows);
    check("revert_no_report", 32'(lows), 32'd0);
    check("revert_no_overrun", 32'(ovr_a), 32'd0);

    // Reset in the middle of the second character's data bits
    val_a = 8'hFF;
    pulse_reset(2);
    wait_start(0, 20, lat, seen);
    repeat (50) tick();
    isReset = 1'b0;
    tick();
    check("abort_txd", 32'(txd_a), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    tick();
    isReset = 1'b1;
    wait_start(0, 20, lat, seen);
    check("ff_latency", 32'(lat), 32'd3);
    rx_bytes(0, 4);
    check_rx("ff_bytes", 4, 40'h0046460D0A);
    wait_idle(0, 20);

    // Randomized value changes, some during reports, occasional resets
    for (int i = 0; i < 36; i++) begin
      r = $urandom_range(0, 2);
      hold = (r == 0) ? $urandom_range(1, 6) : (r == 1) ? $urandom_range(10, 90) : $urandom_range(150, 260);
      val_a = 8'($urandom_range(0, 255));
      repeat (hold) tick();
      if (i % 12 == 11) pulse_reset(2);
    end
    wait_idle(0, 400);
    repeat (5) tick();

    // 10-bit instance: top nibble zero-padded
    pulse_reset(2);
    val_b = 10'h2C5;
    wait_start(1, 20, lat, seen);
    check("w10_latency", 32'(lat), 32'd3);
    rx_bytes(1, 5);
    check_rx("w10_bytes", 5, 40'h3243350D0A);
    wait_idle(1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
